// File: rtl/cache_assoc_param.sv
// cache_assoc_param
// -----------------
// N-way set-associative read cache with one word per line. WAYS=1 gives a
// direct-mapped cache; 2/4/8 give set-associative variants. A miss is served
// from the next level through mem_req_valid/mem_rsp_valid. The victim is the
// lowest-index invalid way, else true LRU (REPL=0) or a per-set round-robin
// pointer (REPL=1). Saturating hit/miss counters are kept in hardware.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE. mem_req_valid stays
// high until mem_rsp_valid is sampled high; rsp_valid is a one-cycle pulse.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr   request port
//   rsp_valid/rsp_data/rsp_hit     one-cycle response
//   mem_req_valid/mem_req_addr     miss request to next level
//   mem_rsp_valid/mem_rsp_data     fill data from next level
//   stat_clr                   synchronous clear of both counters
//   hit_count/miss_count       saturating statistics
//   dbg_state                  current FSM state (IDLE=0, LOOKUP=1, MISS_WAIT=2, RESP=3)
module cache_assoc_param #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    parameter int REPL   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_hit,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [1:0]        dbg_state
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];
    // Age per way: 0 = most recently used, larger = older.
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];
    logic [WAY_W-1:0]  rr_q    [SETS];
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_hit_q;
    logic [CNT_W-1:0]  hit_q, miss_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit, any_inv, fill, acc_en;
    logic [WAY_W-1:0]  hit_way, inv_way, lru_way, victim, acc_way, acc_age, max_age;
    logic [DATA_W-1:0] hit_data;

    assign idx  = addr_q[IDX_W-1:0];
    assign tag  = addr_q[ADDR_W-1:IDX_W];
    assign fill = (state_q == S_MISS_WAIT) && mem_rsp_valid;

    // Tag compare, first invalid way and oldest way of the indexed set.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_data = '0;
        any_inv  = 1'b0;
        inv_way  = '0;
        lru_way  = '0;
        max_age  = age_q[idx][0];
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit      = 1'b1;
                hit_way  = WAY_W'(w);
                hit_data = data_q[idx][w];
            end
            if (!any_inv && !valid_q[idx][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (age_q[idx][w] > max_age) begin
                max_age = age_q[idx][w];
                lru_way = WAY_W'(w);
            end
        end
        if (any_inv)        victim = inv_way;
        else if (REPL == 0) victim = lru_way;
        else                victim = rr_q[idx];
    end

    assign acc_en  = ((state_q == S_LOOKUP) && hit) || fill;
    assign acc_way = fill ? victim : hit_way;

    always_comb begin
        acc_age = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == acc_way) acc_age = age_q[idx][w];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (req_valid) state_d = S_LOOKUP;
            S_LOOKUP:    state_d = hit ? S_RESP : S_MISS_WAIT;
            S_MISS_WAIT: if (mem_rsp_valid) state_d = S_RESP;
            S_RESP:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rsp_data_q <= '0;
            rsp_hit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid) addr_q <= req_addr;
            if (state_q == S_LOOKUP && hit) begin
                rsp_data_q <= hit_data;
                rsp_hit_q  <= 1'b1;
            end else if (fill) begin
                rsp_data_q <= mem_rsp_data;
                rsp_hit_q  <= 1'b0;
            end
        end
    end

    // Valid bits and replacement state are cleared by reset; tag/data are not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= '0;
                end
            end
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (fill && WAY_W'(w) == victim) valid_q[idx][w] <= 1'b1;
            end
            // Accessed way becomes youngest; ways not older than it age by one.
            // Starting from all-zero ages this converges to a permutation.
            if (acc_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == acc_way)
                        age_q[idx][w] <= '0;
                    else if (age_q[idx][w] <= acc_age && age_q[idx][w] != AGE_MAX)
                        age_q[idx][w] <= age_q[idx][w] + 1'b1;
                end
            end
            if (WAYS > 1 && fill && !any_inv) rr_q[idx] <= rr_q[idx] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (fill && WAY_W'(w) == victim) begin
                tag_q[idx][w]  <= tag;
                data_q[idx][w] <= mem_rsp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (stat_clr) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state_q == S_LOOKUP) begin
            if (hit && hit_q != CNT_MAX)    hit_q  <= hit_q + 1'b1;
            if (!hit && miss_q != CNT_MAX)  miss_q <= miss_q + 1'b1;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_data      = rsp_data_q;
    assign rsp_hit       = rsp_hit_q;
    assign mem_req_valid = (state_q == S_MISS_WAIT);
    assign mem_req_addr  = addr_q;
    assign hit_count     = hit_q;
    assign miss_count    = miss_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_cache_assoc_param.sv
module tb_cache_assoc_param;
  localparam int N = 4;   // 0: 4-way LRU, 1: 4-way RR, 2: direct-mapped, 3: 2-way LRU with 4-bit counters

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid     [N];
  logic [10:0] req_addr      [N];
  logic        mem_rsp_valid [N];
  logic [31:0] mem_rsp_data  [N];
  logic        stat_clr      [N];
  logic        req_ready     [N];
  logic        rsp_valid     [N];
  logic [31:0] rsp_data      [N];
  logic        rsp_hit       [N];
  logic        mem_req_valid [N];
  logic [10:0] mem_req_addr  [N];
  logic [15:0] hit_cnt       [N];
  logic [15:0] miss_cnt      [N];
  logic [1:0]  dbg_state     [N];

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int WY = (g < 2) ? 4 : ((g == 2) ? 1 : 2);
      localparam int RP = (g == 1) ? 1 : 0;
      localparam int CW = (g == 3) ? 4 : 16;
      logic [CW-1:0] hc, mc;
      cache_assoc_param #(.ADDR_W(11), .DATA_W(32), .WAYS(WY), .SETS(16), .REPL(RP), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
        .rsp_valid(rsp_valid[g]), .rsp_data(rsp_data[g]), .rsp_hit(rsp_hit[g]),
        .mem_req_valid(mem_req_valid[g]), .mem_req_addr(mem_req_addr[g]),
        .mem_rsp_valid(mem_rsp_valid[g]), .mem_rsp_data(mem_rsp_data[g]),
        .stat_clr(stat_clr[g]), .hit_count(hc), .miss_count(mc), .dbg_state(dbg_state[g])
      );
      assign hit_cnt[g]  = 16'(hc);
      assign miss_cnt[g] = 16'(mc);
    end
  endgenerate

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: resident tags, last-use time, RR pointer
  bit     m_valid [N][16][4];
  int     m_tag   [N][16][4];
  longint m_last  [N][16][4];
  int     m_rr    [N][16];
  longint tick;
  int     exp_hit [N];
  int     exp_miss[N];

  function automatic int ways_of(input int i);
    return (i < 2) ? 4 : ((i == 2) ? 1 : 2);
  endfunction

  function automatic int cmax(input int i);
    return (i == 3) ? 15 : 65535;
  endfunction

  function automatic logic [31:0] mem_word(input logic [10:0] a);
    return 32'hC0DE0000 ^ {21'd0, a} ^ ({21'd0, a} << 17);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      exp_hit[i] = 0;
      exp_miss[i] = 0;
      for (int s = 0; s < 16; s++) begin
        m_rr[i][s] = 0;
        for (int w = 0; w < 4; w++) begin
          m_valid[i][s][w] = 1'b0;
          m_last[i][s][w] = 0;
        end
      end
    end
  endfunction

  function automatic bit model_access(input int i, input logic [10:0] a);
    int s = int'(a) % 16;
    int t = int'(a) / 16;
    int n = ways_of(i);
    int v = -1;
    tick++;
    for (int w = 0; w < n; w++) begin
      if (m_valid[i][s][w] && m_tag[i][s][w] == t) begin
        m_last[i][s][w] = tick;
        return 1'b1;
      end
    end
    for (int w = n - 1; w >= 0; w--) if (!m_valid[i][s][w]) v = w;
    if (v < 0) begin
      if (i == 1) begin
        v = m_rr[i][s];
        m_rr[i][s] = (m_rr[i][s] + 1) % n;
      end else begin
        v = 0;
        for (int w = 1; w < n; w++) if (m_last[i][s][w] < m_last[i][s][v]) v = w;
      end
    end
    m_valid[i][s][v] = 1'b1;
    m_tag[i][s][v] = t;
    m_last[i][s][v] = tick;
    return 1'b0;
  endfunction

  // ---------------- driver: one read, all checks at negedges
  task automatic do_read(input int i, input logic [10:0] a, input bit clr, output bit hit_seen);
    bit exp_h;
    int lat;
    check_eq("ready_idle", req_ready[i], 1'b1);
    req_valid[i] = 1'b1;
    req_addr[i]  = a;
    @(negedge clk);
    req_valid[i]     = 1'b0;
    req_addr[i]      = 11'($urandom);
    stat_clr[i]      = clr;
    mem_rsp_valid[i] = 1'($urandom_range(0, 1));   // stray pulse, must be ignored
    mem_rsp_data[i]  = $urandom;
    check_eq("ready_busy", req_ready[i], 1'b0);
    exp_h = model_access(i, a);
    if (clr) begin
      exp_hit[i] = 0;
      exp_miss[i] = 0;
    end else if (exp_h) begin
      if (exp_hit[i] < cmax(i)) exp_hit[i]++;
    end else begin
      if (exp_miss[i] < cmax(i)) exp_miss[i]++;
    end
    @(negedge clk);
    stat_clr[i]      = 1'b0;
    mem_rsp_valid[i] = 1'b0;
    hit_seen = rsp_valid[i] && rsp_hit[i];
    if (exp_h) begin
      check_eq("hit_rsp_valid", rsp_valid[i], 1'b1);
      check_eq("hit_rsp_hit", rsp_hit[i], 1'b1);
      check_eq("hit_rsp_data", rsp_data[i], mem_word(a));
      check_eq("hit_no_memreq", mem_req_valid[i], 1'b0);
    end else begin
      check_eq("miss_rsp_valid", rsp_valid[i], 1'b0);
      check_eq("miss_memreq", mem_req_valid[i], 1'b1);
      check_eq("miss_memaddr", mem_req_addr[i], a);
      lat = $urandom_range(0, 3);
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        check_eq("miss_hold", mem_req_valid[i], 1'b1);
      end
      mem_rsp_valid[i] = 1'b1;
      mem_rsp_data[i]  = mem_word(a);
      @(negedge clk);
      mem_rsp_valid[i] = 1'b0;
      mem_rsp_data[i]  = $urandom;
      check_eq("fill_rsp_valid", rsp_valid[i], 1'b1);
      check_eq("fill_rsp_hit", rsp_hit[i], 1'b0);
      check_eq("fill_rsp_data", rsp_data[i], mem_word(a));
      check_eq("fill_memreq_drop", mem_req_valid[i], 1'b0);
    end
    check_eq("hit_count", hit_cnt[i], 16'(exp_hit[i]));
    check_eq("miss_count", miss_cnt[i], 16'(exp_miss[i]));
    @(negedge clk);
    check_eq("rsp_pulse_end", rsp_valid[i], 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] seq [8];
    bit          lru_exp [8];
    bit          h;
    seq     = '{11'd0, 11'd16, 11'd32, 11'd48, 11'd0, 11'd64, 11'd0, 11'd16};
    lru_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tick = 0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i] = '0;
      mem_rsp_valid[i] = 1'b0;
      mem_rsp_data[i] = '0;
      stat_clr[i] = 1'b0;
    end

    // reset values
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_eq("rst_ready", req_ready[i], 1'b1);
      check_eq("rst_rsp_valid", rsp_valid[i], 1'b0);
      check_eq("rst_rsp_hit", rsp_hit[i], 1'b0);
      check_eq("rst_rsp_data", rsp_data[i], 32'd0);
      check_eq("rst_memreq", mem_req_valid[i], 1'b0);
      check_eq("rst_memaddr", mem_req_addr[i], 11'd0);
      check_eq("rst_hitcnt", hit_cnt[i], 16'd0);
      check_eq("rst_misscnt", miss_cnt[i], 16'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 4-way LRU: fills, hit, eviction of the least recently used line
    for (int k = 0; k < 8; k++) begin
      do_read(0, seq[k], 1'b0, h);
      check_eq("lru_seq_hit", h, lru_exp[k]);
    end
    check_eq("lru_hitcnt", hit_cnt[0], 16'd2);
    check_eq("lru_misscnt", miss_cnt[0], 16'd6);

    // 4-way round-robin on the same sequence
    for (int k = 0; k < 8; k++) do_read(1, seq[k], 1'b0, h);

    // direct-mapped vs 2-way on 0,16,0
    for (int k = 0; k < 3; k++) do_read(2, (k == 1) ? 11'd16 : 11'd0, 1'b0, h);
    check_eq("dm_misscnt", miss_cnt[2], 16'd3);
    check_eq("dm_hitcnt", hit_cnt[2], 16'd0);
    for (int k = 0; k < 3; k++) do_read(3, (k == 1) ? 11'd16 : 11'd0, 1'b0, h);
    check_eq("w2_misscnt", miss_cnt[3], 16'd2);
    check_eq("w2_hitcnt", hit_cnt[3], 16'd1);

    // 4-bit counter saturation, then clear coinciding with a hit
    for (int k = 0; k < 21; k++) do_read(3, 11'd5, 1'b0, h);
    check_eq("sat_hitcnt", hit_cnt[3], 16'd15);
    do_read(3, 11'd5, 1'b1, h);
    check_eq("clr_hitcnt", hit_cnt[3], 16'd0);

    // reset while a miss is pending
    req_valid[0] = 1'b1;
    req_addr[0]  = 11'd2047;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("pend_memreq", mem_req_valid[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_memreq", mem_req_valid[0], 1'b0);
    check_eq("rstmid_ready", req_ready[0], 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstrel_ready", req_ready[0], 1'b1);
    mem_rsp_valid[0] = 1'b1;
    mem_rsp_data[0]  = 32'hDEADBEEF;
    @(negedge clk);
    mem_rsp_valid[0] = 1'b0;
    check_eq("late_rsp_ignored", rsp_valid[0], 1'b0);
    check_eq("late_rsp_memreq", mem_req_valid[0], 1'b0);
    do_read(0, 11'd2047, 1'b0, h);
    check_eq("after_rst_miss", h, 1'b0);

    // randomized traffic on a small address pool per instance
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 60; k++) begin
        logic [10:0] a;
        a = 11'($urandom_range(0, 5) * 16 + $urandom_range(0, 3));
        do_read(i, a, ($urandom_range(0, 15) == 0), h);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
